// File: rtl/dwc_pkg.sv
// Shared constants, FSM state type and address helper for the 32-to-512
// transmit-side width converter.
package dwc_pkg;

    localparam int WORDS_PER_BEAT = 16;
    localparam int WORD_W         = 32;
    localparam int BEAT_W         = 512;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } dwc_state_t;

    // Word index to byte address; only the low 16 index bits are addressable.
    function automatic logic [31:0] word_addr(input logic [15:0] word_index);
        return {14'd0, word_index, 2'b00};
    endfunction

endpackage

// File: rtl/dwc_beat_assembler.sv
// Collects 16 returning 32-bit words into one 512-bit beat and hands it to
// the streaming output register. The first word lands in the LSBs. While a
// full beat waits for the output register, the fetch side must stall.
module dwc_beat_assembler
    import dwc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              word_valid_i,   // read data present this cycle
    input  logic [WORD_W-1:0] word_i,
    input  logic              first_beat_i,
    input  logic              last_beat_i,
    input  logic              ready_i,        // effective sink ready
    output logic              empty_o,        // nothing filling, nothing held
    output logic              handoff_o,      // beat moves to output this cycle
    output logic [BEAT_W-1:0] src_dout_o,
    output logic              src_valid_o,
    output logic              src_sop_o,
    output logic              src_eop_o
);

    logic [BEAT_W-1:0] buf_q;
    logic [3:0]        fill_q;
    logic              full_q;
    logic [BEAT_W-1:0] dout_q;
    logic              valid_q;
    logic              sop_q;
    logic              eop_q;

    // A full beat may move out when the output slot is free or drains now.
    assign handoff_o = full_q && (!valid_q || ready_i);

    // An in-flight word still counts as filling, so the next beat waits for it.
    assign empty_o = !full_q && (fill_q == 4'd0) && !word_valid_i;

    assign src_dout_o  = dout_q;
    assign src_valid_o = valid_q;
    assign src_sop_o   = sop_q;
    assign src_eop_o   = eop_q;

    // Shift buffer, fill count and full flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_q  <= '0;
            fill_q <= 4'd0;
            full_q <= 1'b0;
        end else begin
            if (word_valid_i) begin
                buf_q  <= {word_i, buf_q[BEAT_W-1:WORD_W]};
                fill_q <= fill_q + 4'd1;
                if (fill_q == 4'd15) begin
                    full_q <= 1'b1;
                end
            end
            if (handoff_o) begin
                full_q <= 1'b0;
            end
        end
    end

    // Output register: load on handoff, hold until accepted, then go empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
        end else if (handoff_o) begin
            dout_q  <= buf_q;
            valid_q <= 1'b1;
            sop_q   <= first_beat_i;
            eop_q   <= last_beat_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
        end
    end

endmodule

// File: rtl/datawidthconv_32_to_512.sv
// Drains BEATS*16 words from a word-addressed 32-bit memory and emits them
// as a 512-bit sop/eop/valid packet, one packet per accepted start pulse.
// Optional macro DWC_32_TO_512_READY_EN: honour src_ready backpressure.
// Without it every beat is shown for exactly one cycle and src_ready is
// ignored.
module datawidthconv_32_to_512
    import dwc_pkg::*;
#(
    parameter int BEATS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [31:0]       data_addr,
    output logic              data_oe,
    input  logic [WORD_W-1:0] data_dout,
    output logic              src_sop,
    output logic              src_eop,
    output logic              src_valid,
    output logic [BEAT_W-1:0] src_dout,
    input  logic              src_ready
);

    localparam logic [16:0] LAST_WORD = 17'(BEATS * WORDS_PER_BEAT - 1);
    localparam logic [12:0] LAST_BEAT = 13'(BEATS - 1);

    dwc_state_t  state_q, state_d;
    logic [16:0] word_cnt_q, word_cnt_d;
    logic [12:0] beat_cnt_q;
    logic        done_q, done_d;
    logic        rd_pend_q;
    logic        issue;
    logic        ready_eff;
    logic        asm_empty;
    logic        handoff;

`ifdef DWC_32_TO_512_READY_EN
    assign ready_eff = src_ready;
`else
    // Port kept for interface compatibility; its value never matters.
    assign ready_eff = src_ready | 1'b1;
`endif

    // Next-state logic: issue reads, stall at beat boundaries, finish on eop.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        issue      = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = FETCH;
                    word_cnt_d = '0;
                end
            end
            FETCH: begin
                // First word of a beat waits until the assembler is free.
                if ((word_cnt_q[3:0] != 4'd0) || asm_empty) begin
                    issue      = 1'b1;
                    word_cnt_d = word_cnt_q + 17'd1;
                    if (word_cnt_q == LAST_WORD) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (src_valid && ready_eff && src_eop) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters, done pulse and read-in-flight tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            done_q     <= 1'b0;
            rd_pend_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            done_q     <= done_d;
            rd_pend_q  <= issue;
        end
    end

    // Beat index, used to frame the beat being handed to the output.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt_q <= '0;
        end else if (state_q == IDLE && start) begin
            beat_cnt_q <= '0;
        end else if (handoff) begin
            beat_cnt_q <= beat_cnt_q + 13'd1;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign data_oe   = issue;
    assign data_addr = issue ? word_addr(word_cnt_q[15:0]) : 32'd0;

    dwc_beat_assembler u_asm (
        .clk          (clk),
        .reset        (reset),
        .word_valid_i (rd_pend_q),
        .word_i       (data_dout),
        .first_beat_i (beat_cnt_q == 13'd0),
        .last_beat_i  (beat_cnt_q == LAST_BEAT),
        .ready_i      (ready_eff),
        .empty_o      (asm_empty),
        .handoff_o    (handoff),
        .src_dout_o   (src_dout),
        .src_valid_o  (src_valid),
        .src_sop_o    (src_sop),
        .src_eop_o    (src_eop)
    );

endmodule
